// File: rtl/alu_md_pkg.sv
// Shared types, decode constants and the request decoder for the
// ALU / multiply-divide execute unit.
package alu_md_pkg;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
        OP_OR, OP_AND, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
        OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILLEGAL
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE, S_MUL, S_DIV, S_DONE
    } md_state_t;

    localparam logic [1:0] AOP_ADD = 2'b00;
    localparam logic [1:0] AOP_SUB = 2'b01;
    localparam logic [1:0] AOP_R   = 2'b10;
    localparam logic [1:0] AOP_I   = 2'b11;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MD   = 7'b0000001;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    function automatic alu_op_t base_op(input logic [2:0] f3);
        alu_op_t op;
        op = OP_ADD;
        unique case (f3)
            F3_ADD:  op = OP_ADD;
            F3_SLL:  op = OP_SLL;
            F3_SLT:  op = OP_SLT;
            F3_SLTU: op = OP_SLTU;
            F3_XOR:  op = OP_XOR;
            F3_SR:   op = OP_SRL;
            F3_OR:   op = OP_OR;
            F3_AND:  op = OP_AND;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

    function automatic alu_op_t md_op(input logic [2:0] f3);
        alu_op_t op;
        op = OP_MUL;
        unique case (f3)
            3'b000:  op = OP_MUL;
            3'b001:  op = OP_MULH;
            3'b010:  op = OP_MULHSU;
            3'b011:  op = OP_MULHU;
            3'b100:  op = OP_DIV;
            3'b101:  op = OP_DIVU;
            3'b110:  op = OP_REM;
            3'b111:  op = OP_REMU;
            default: op = OP_MUL;
        endcase
        return op;
    endfunction

    function automatic alu_op_t decode(
        input logic [1:0] aop,
        input logic [6:0] f7,
        input logic [2:0] f3
    );
        alu_op_t op;
        op = OP_ILLEGAL;
        unique case (aop)
            AOP_ADD: op = OP_ADD;
            AOP_SUB: op = OP_SUB;
            AOP_R: begin
                if (f7 == F7_BASE)
                    op = base_op(f3);
                else if (f7 == F7_MD)
                    op = md_op(f3);
                else if (f7 == F7_ALT && f3 == F3_ADD)
                    op = OP_SUB;
                else if (f7 == F7_ALT && f3 == F3_SR)
                    op = OP_SRA;
            end
            AOP_I: begin
                // Only the shift immediates carry an opcode in func_7.
                if (f3 == F3_SLL)
                    op = (f7 == F7_BASE) ? OP_SLL : OP_ILLEGAL;
                else if (f3 == F3_SR && f7 == F7_BASE)
                    op = OP_SRL;
                else if (f3 == F3_SR && f7 == F7_ALT)
                    op = OP_SRA;
                else if (f3 != F3_SR)
                    op = base_op(f3);
            end
            default: op = OP_ILLEGAL;
        endcase
        return op;
    endfunction

    function automatic logic is_mul_op(input alu_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    function automatic logic is_div_op(input alu_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/alu_md_unit_mdu_iter.sv
// Iterative radix-2 multiply / restoring divide on operand magnitudes,
// one bit per cycle, with the sign fix-up folded into the last step.
module mdu_iter
    import alu_md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start,
    input  alu_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            fin,
    output logic [XLEN-1:0] res
);
    localparam int CW = $clog2(XLEN) + 1;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] p_q, p_d;
    logic [XLEN-1:0]   m_q, m_d;
    alu_op_t           op_q, op_d;
    logic              sgn_q, sgn_d;
    logic              asgn_q, asgn_d;

    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, r_sh, diff;
    logic [2*XLEN-1:0] step_p, prod;
    logic [XLEN-1:0]   quo, rem;

    always_comb begin
        a_neg = 1'b0;
        b_neg = 1'b0;
        if (op inside {OP_MULH, OP_DIV, OP_REM}) begin
            a_neg = a[XLEN-1];
            b_neg = b[XLEN-1];
        end else if (op == OP_MULHSU) begin
            a_neg = a[XLEN-1];
        end
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    always_comb begin
        mul_sum = {1'b0, p_q[2*XLEN-1:XLEN]}
                + (p_q[0] ? {1'b0, m_q} : '0);
        r_sh    = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
        diff    = r_sh - {1'b0, m_q};
        if (is_mul_op(op_q))
            step_p = {mul_sum, p_q[XLEN-1:1]};
        else if (diff[XLEN])
            step_p = {r_sh[XLEN-1:0], p_q[XLEN-2:0], 1'b0};
        else
            step_p = {diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
        prod = sgn_q ? -step_p : step_p;
        quo  = sgn_q ? -step_p[XLEN-1:0] : step_p[XLEN-1:0];
        rem  = asgn_q ? -step_p[2*XLEN-1:XLEN] : step_p[2*XLEN-1:XLEN];
    end

    always_comb begin
        res = '0;
        unique case (op_q)
            OP_MUL:                       res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              res = quo;
            OP_REM, OP_REMU:              res = rem;
            default:                      res = '0;
        endcase
    end

    assign fin = (cnt_q == CW'(1));

    always_comb begin
        cnt_d  = cnt_q;
        p_d    = p_q;
        m_d    = m_q;
        op_d   = op_q;
        sgn_d  = sgn_q;
        asgn_d = asgn_q;
        if (flush) begin
            cnt_d = '0;
            p_d   = '0;
            m_d   = '0;
        end else if (start) begin
            cnt_d  = CW'(XLEN);
            p_d    = {{XLEN{1'b0}}, is_mul_op(op) ? b_mag : a_mag};
            m_d    = is_mul_op(op) ? a_mag : b_mag;
            op_d   = op;
            sgn_d  = a_neg ^ b_neg;
            asgn_d = a_neg;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            p_d   = step_p;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            p_q    <= '0;
            m_q    <= '0;
            op_q   <= OP_ADD;
            sgn_q  <= 1'b0;
            asgn_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            p_q    <= p_d;
            m_q    <= m_d;
            op_q   <= op_d;
            sgn_q  <= sgn_d;
            asgn_q <= asgn_d;
        end
    end

endmodule

// File: rtl/alu_md_unit.sv
// Execute unit: single-cycle RV32I ALU plus iterative RV32M datapath
// behind a valid/ready request and a held, registered result.
module alu_md_unit
    import alu_md_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [6:0]      func_7,
    input  logic [2:0]      func_3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal
);
    md_state_t       state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            illegal_q, illegal_d;

    alu_op_t         dec;
    logic [SHW-1:0]  shamt;
    logic            divz, ovf, short_div;
    logic [XLEN-1:0] alu_res, md_res;
    logic            md_start, md_fin;

    assign dec   = decode(alu_op, func_7, func_3);
    assign shamt = op_b[SHW-1:0];
    assign divz  = (op_b == '0);
    assign ovf   = (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b);
    // Corner-case divides resolve immediately without iterating.
    assign short_div = divz || (ovf && (dec inside {OP_DIV, OP_REM}));

    always_comb begin
        alu_res = '0;
        unique case (dec)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_SLL:  alu_res = op_a << shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SRL:  alu_res = op_a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
            OP_OR:   alu_res = op_a | op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_DIV, OP_DIVU: alu_res = divz ? '1 : op_a;
            OP_REM, OP_REMU: alu_res = divz ? op_a : '0;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        md_start  = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: if (in_valid) begin
                    if (is_mul_op(dec)) begin
                        state_d  = S_MUL;
                        md_start = 1'b1;
                    end else if (is_div_op(dec) && !short_div) begin
                        state_d  = S_DIV;
                        md_start = 1'b1;
                    end else begin
                        state_d   = S_DONE;
                        result_d  = alu_res;
                        illegal_d = (dec == OP_ILLEGAL);
                    end
                end
                S_MUL, S_DIV: if (md_fin) begin
                    state_d   = S_DONE;
                    result_d  = md_res;
                    illegal_d = 1'b0;
                end
                S_DONE: if (out_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    mdu_iter #(.XLEN(XLEN)) u_mdu (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .start (md_start),
        .op    (dec),
        .a     (op_a),
        .b     (op_b),
        .fin   (md_fin),
        .res   (md_res)
    );

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign illegal   = illegal_q;

endmodule

// File: doc/alu_md_unit.md
# alu_md_unit

Parametrised execute unit that supersedes the combinational ALU control decode. It takes the main decoder's `alu_op`, the full `func_7` and `func_3` fields and two operands, and returns a registered result over a valid/ready handshake. It adds the full RV32I ALU op set, the RV32M multiply/divide ops through an iterative datapath, and an illegal-combination flag in place of a simulation-only error. It sits between register read and writeback in the core pipeline.

## Interface
- `XLEN`, default 32: operand/result width; must be a power of two and ≥ 8.
- `SHW`, default `$clog2(XLEN)`: shift-amount width; derived, not overridden.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous kill of any in-flight or held operation.
- `in_valid` input 1: request valid.
- `in_ready` output 1: unit can accept a request.
- `alu_op` input 2: 00 ADD (load/store address), 01 SUB (branch), 10 R-type, 11 I-type.
- `func_7` input 7: instruction [31:25].
- `func_3` input 3: instruction [14:12].
- `op_a` input XLEN: rs1 value.
- `op_b` input XLEN: rs2 value or immediate.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `result` output XLEN: registered result.
- `illegal` output 1: qualifies `out_valid`; the decode combination was illegal.

## Operation
- Decode at accept:
  - `alu_op` 00 → ADD; 01 → SUB; `func_7`/`func_3` are ignored for both.
- R-type, `func_7` = 0000000:
  - `func_3` 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
- R-type, `func_7` = 0100000:
  - `func_3` 000 SUB, 101 SRA; any other `func_3` is illegal.
- R-type, `func_7` = 0000001:
  - `func_3` 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- R-type, any other `func_7`: illegal.
- I-type:
  - `func_7` is ignored except for shifts.
  - `func_3` 001 requires `func_7` = 0000000.
  - `func_3` 101 requires 0000000 (SRLI) or 0100000 (SRAI).
  - Any other `func_7` on those shifts is illegal. No M ops in I-type.
- Shifts use `op_b[SHW-1:0]`. SLT/SLTU produce 0 or 1, zero-extended.
- MUL returns the low XLEN bits. MULH/MULHSU/MULHU return the high XLEN bits of the 2·XLEN signed×signed, signed×unsigned and unsigned×unsigned product.
- Divide by zero: quotient = all ones, remainder = `op_a`.
- Signed overflow (−2^(XLEN−1) / −1): quotient = `op_a`, remainder = 0.
- Illegal request: `result` = 0, `illegal` = 1.
- FSM states:
  - IDLE: `in_ready` = 1. On `in_valid && !flush`:
    - ALU or illegal request → DONE.
    - MUL* → MUL.
    - DIV*/REM* → DIV, except divide-by-zero and overflow, which go → DONE.
  - MUL / DIV: iterate one bit per cycle on an XLEN-cycle down-counter (radix-2 shift-add multiply, restoring divide on operand magnitudes, sign fix-up on the final iteration); → DONE when the counter reaches 0.
  - DONE: `out_valid` = 1; `result`/`illegal` held stable until `out_ready`, then → IDLE.
- `in_ready` = (state == IDLE). There is no accept in the same cycle as a DONE handoff.
- `flush` in any state → IDLE at the next edge, drops `out_valid`, discards work; `flush` has priority over `in_valid`.
- Reset (asynchronous, any state including mid-iteration): state IDLE, `out_valid` 0, `result` 0, `illegal` 0, counter 0, internal accumulators 0. `in_ready` reads 1 during and after reset.

## Timing
- Request accepted at edge k (`in_valid && in_ready && !flush`).
- ALU, illegal, div-by-zero and overflow requests: `out_valid` high after edge k+1.
- MUL*/DIV*/REM*: `out_valid` high after edge k+XLEN+1 (33 cycles for XLEN=32).
- Handoff at edge j (`out_valid && out_ready`): `out_valid` low after edge j; `in_ready` high after edge j.
- Throughput: one ALU op per 2 cycles.
- Outputs are driven only from registers; `in_ready` is decoded from the state register.

## Structure
- Package `alu_md_pkg`:
  - `alu_op_t` enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, ILLEGAL.
  - `alu_op` encodings.
  - `func_3`/`func_7` constants.
  - `md_state_t` enum: IDLE, MUL, DIV, DONE.
  - Combinational decode function (`alu_op`, `func_7`, `func_3` → `alu_op_t`).
- One sub-module, `mdu_iter`: iterative multiply/divide datapath with counter, accumulators and sign fix-up; start/done handshake to the top FSM; flush input.

## Test plan
- ADD 5 + 7 (`alu_op`=10, `func_7`=0, `func_3`=000) → `result` = 12, `illegal` = 0, `out_valid` one cycle after accept.
- SRA 0x8000_0000 >> 4 (`func_7`=0100000, `func_3`=101) → 0xF800_0000; SRL same operands → 0x0800_0000.
- MULH 0xFFFF_FFFF × 2 → 0xFFFF_FFFF; MULHU same operands → 0x0000_0001; `out_valid` exactly 33 cycles after accept.
- Divide edge cases:
  - DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000 after 1 cycle.
  - DIVU 9 / 0 → 0xFFFF_FFFF.
  - REM −7 / 2 → 0xFFFF_FFFF (−1).
- R-type `func_7`=0100000 with `func_3`=111 → `illegal` = 1, `result` = 0; hold `out_ready` low 5 cycles → outputs stable throughout.
- Start DIV; assert `flush` at iteration 10 → IDLE next cycle with no `out_valid`. Start MUL; pulse `rst_n` low mid-iteration → all outputs 0 and `in_ready` = 1; a new ADD then completes normally.
